// File: rtl/tmds_decoder.sv
// TMDS receive-side word aligner and 10b/8b decoder for one channel.
// Optional lock-loss statistics counter enabled by TMDS_DECODER_LOCK_STATS_EN.
module tmds_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       locked_out,
  output logic [3:0] offset_out,
  output logic [7:0] lock_loss_count_out
);

  localparam int TMO_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int TW      = $clog2(TMO_MAX + 1);
  localparam int VW      = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t          state, state_n;
  logic [3:0]      offset, offset_n, offset_inc;
  logic [TW-1:0]   tmo_cnt, tmo_cnt_n;
  logic [VW-1:0]   ver_cnt, ver_cnt_n;
  logic [9:0]      prev_word;
  logic [9:0]      window;
  logic            tok;
  logic [1:0]      tok_code;
  logic [7:0]      d, dec;

  // Bits received first sit in prev_word, so the window slides upward from it.
  assign window     = 10'({tmds_in, prev_word} >> offset);
  assign offset_inc = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
  assign offset_out = offset;

  always_comb begin
    tok      = 1'b1;
    tok_code = 2'b00;
    case (window)
      10'b1101010100: tok_code = 2'b00;
      10'b0010101011: tok_code = 2'b01;
      10'b0101010100: tok_code = 2'b10;
      10'b1010101011: tok_code = 2'b11;
      default:        tok      = 1'b0;
    endcase
  end

  always_comb begin
    d      = window[9] ? ~window[7:0] : window[7:0];
    dec    = '0;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++)
      dec[i] = window[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n   = state;
    offset_n  = offset;
    tmo_cnt_n = tmo_cnt;
    ver_cnt_n = ver_cnt;
    case (state)
      SEARCH: begin
        if (tok) begin
          tmo_cnt_n = '0;
          if (LOCK_COUNT <= 1) begin
            state_n   = LOCKED;
            ver_cnt_n = '0;
          end else begin
            state_n   = VERIFY;
            ver_cnt_n = VW'(1);
          end
        end else if (tmo_cnt == TW'(SEARCH_TIMEOUT - 1)) begin
          tmo_cnt_n = '0;
          offset_n  = offset_inc;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end
      VERIFY: begin
        if (tok) begin
          if (ver_cnt == VW'(LOCK_COUNT - 1)) begin
            state_n   = LOCKED;
            tmo_cnt_n = '0;
            ver_cnt_n = '0;
          end else begin
            ver_cnt_n = ver_cnt + 1'b1;
          end
        end else begin
          state_n   = SEARCH;
          offset_n  = offset_inc;
          tmo_cnt_n = '0;
          ver_cnt_n = '0;
        end
      end
      LOCKED: begin
        if (tok) begin
          tmo_cnt_n = '0;
        end else if (tmo_cnt == TW'(LOSS_TIMEOUT - 1)) begin
          state_n   = SEARCH;
          tmo_cnt_n = '0;
          ver_cnt_n = '0;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end
      default: begin
        state_n   = SEARCH;
        offset_n  = '0;
        tmo_cnt_n = '0;
        ver_cnt_n = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= SEARCH;
      offset      <= '0;
      tmo_cnt     <= '0;
      ver_cnt     <= '0;
      prev_word   <= '0;
      data_out    <= '0;
      control_out <= '0;
      ve_out      <= 1'b0;
      locked_out  <= 1'b0;
    end else begin
      state     <= state_n;
      offset    <= offset_n;
      tmo_cnt   <= tmo_cnt_n;
      ver_cnt   <= ver_cnt_n;
      prev_word <= tmds_in;
      // Outputs track the state being entered, so the transition cycle already reflects it.
      if (state_n == LOCKED) begin
        locked_out <= 1'b1;
        if (tok) begin
          ve_out      <= 1'b0;
          data_out    <= '0;
          control_out <= tok_code;
        end else begin
          ve_out   <= 1'b1;
          data_out <= dec;
        end
      end else begin
        locked_out  <= 1'b0;
        ve_out      <= 1'b0;
        data_out    <= '0;
        control_out <= '0;
      end
    end
  end

`ifdef TMDS_DECODER_LOCK_STATS_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      loss_cnt <= '0;
    else if (state == LOCKED && state_n == SEARCH && loss_cnt != 8'hFF)
      loss_cnt <= loss_cnt + 8'd1;
  end

  assign lock_loss_count_out = loss_cnt;
`else
  assign lock_loss_count_out = '0;
`endif

endmodule
